// File: rtl/axil_kg_regfile.sv
// AXI4-Lite register file holding the four Kugelblitz offload control registers.
// Optional macro AXIL_KG_REGFILE_ID_EN adds a read-only ID register at offset 0x10.
module axil_kg_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [DATA_WIDTH-1:0] kg_address,
  output logic [DATA_WIDTH-1:0] kg_address_valid,
  output logic [DATA_WIDTH-1:0] kg_data,
  output logic [DATA_WIDTH-1:0] kg_data_valid
);

`ifdef AXIL_KG_REGFILE_ID_EN
  localparam logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'h4B47_0001);
`endif

  logic [DATA_WIDTH-1:0] regs [4];
  logic                  wr_accept;
  logic                  rd_accept;
  logic [2:0]            wr_idx;
  logic [2:0]            rd_idx;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  unused_bits;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // AW and W are accepted together only, and only while no B response is pending;
  // AR is accepted only while no R response is pending. Responses hold until ready.
  assign wr_accept      = s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid & ~rst;
  assign s_axil_awready = wr_accept;
  assign s_axil_wready  = wr_accept;
  assign s_axil_arready = ~s_axil_rvalid & ~rst;
  assign rd_accept      = s_axil_arvalid & s_axil_arready;

  assign wr_idx = s_axil_awaddr[4:2];
  assign rd_idx = s_axil_araddr[4:2];

  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  assign kg_address       = regs[0];
  assign kg_address_valid = regs[1];
  assign kg_data          = regs[2];
  assign kg_data_valid    = regs[3];

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) regs[r] <= '0;
    end else if (wr_accept && !wr_idx[2]) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axil_wstrb[i]) regs[wr_idx[1:0]][8*i +: 8] <= s_axil_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_value = '0;
    case (rd_idx)
      3'd0: rd_value = regs[0];
      3'd1: rd_value = regs[1];
      3'd2: rd_value = regs[2];
      3'd3: rd_value = regs[3];
`ifdef AXIL_KG_REGFILE_ID_EN
      3'd4: rd_value = ID_VALUE;
`endif
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_bvalid <= 1'b0;
    end else if (wr_accept) begin
      s_axil_bvalid <= 1'b1;
    end else if (s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
    end
  end

  // rdata samples the registers before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (rd_accept) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_value;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_kg_regfile.sv
// Bench for axil_kg_regfile: directed bus scenarios plus random traffic against a cycle model.
module tb_axil_kg_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, kg_address, kg_address_valid, kg_data, kg_data_valid;

  int n_checks = 0;
  int n_errors = 0;

  axil_kg_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .kg_address(kg_address), .kg_address_valid(kg_address_valid),
    .kg_data(kg_data), .kg_data_valid(kg_data_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: state after each edge, plus effects scheduled for the next edge
  logic [31:0] m_regs [4] = '{default: '0};
  logic        m_bvalid = 0, m_rvalid = 0, armed = 0;
  logic [31:0] m_rdata = '0;
  logic        p_rst = 0, p_wr = 0, p_rd = 0, p_bclr = 0, p_rclr = 0;
  logic [2:0]  p_widx = '0;
  logic [31:0] p_wdata = '0, p_rdata = '0;
  logic [3:0]  p_wstrb = '0;
  logic        exp_awr, exp_arr;

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    if (idx < 3'd4) return m_regs[idx[1:0]];
`ifdef AXIL_KG_REGFILE_ID_EN
    if (idx == 3'd4) return 32'h4B47_0001;
`endif
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (p_rst) begin
      for (int r = 0; r < 4; r++) m_regs[r] = '0;
      m_bvalid = 0; m_rvalid = 0; m_rdata = '0; armed = 1;
    end else begin
      if (p_wr) begin
        m_bvalid = 1;
        if (p_widx < 3'd4)
          for (int b = 0; b < 4; b++)
            if (p_wstrb[b]) m_regs[p_widx[1:0]][8*b +: 8] = p_wdata[8*b +: 8];
      end else if (p_bclr) m_bvalid = 0;
      if (p_rd) begin
        m_rvalid = 1; m_rdata = p_rdata;
      end else if (p_rclr) m_rvalid = 0;
    end
    exp_awr = awvalid & wvalid & ~m_bvalid & ~rst;
    exp_arr = ~m_rvalid & ~rst;
    if (armed) begin
      check("mon_kg_address", kg_address, m_regs[0]);
      check("mon_kg_address_valid", kg_address_valid, m_regs[1]);
      check("mon_kg_data", kg_data, m_regs[2]);
      check("mon_kg_data_valid", kg_data_valid, m_regs[3]);
      check("mon_bvalid", bvalid, m_bvalid);
      check("mon_rvalid", rvalid, m_rvalid);
      check("mon_rdata", rdata, m_rdata);
      check("mon_bresp", bresp, 0);
      check("mon_rresp", rresp, 0);
      check("mon_awready", awready, exp_awr);
      check("mon_wready", wready, exp_awr);
      check("mon_arready", arready, exp_arr);
    end
    p_rst = rst;
    p_wr = exp_awr;
    p_widx = awaddr[4:2]; p_wdata = wdata; p_wstrb = wstrb;
    p_rd = arvalid & exp_arr;
    p_rdata = model_read(araddr[4:2]);
    p_bclr = m_bvalid & bready;
    p_rclr = m_rvalid & rready;
  end

  // driver tasks
  task automatic wait_aw_accept(input string name);
    int n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    wait_aw_accept("write");
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    check("write_bvalid", bvalid, 1);
    check("write_bresp", bresp, 0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1; rready = 1;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("read_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 0;
    check("read_rvalid", rvalid, 1);
    check("read_rresp", rresp, 0);
    d = rdata;
  endtask

  logic [31:0] rd;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_kg_address", kg_address, 0);
    check("reset_kg_address_valid", kg_address_valid, 0);
    check("reset_kg_data", kg_data, 0);
    check("reset_kg_data_valid", kg_data_valid, 0);
    check("reset_bvalid", bvalid, 0);
    check("reset_rvalid", rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      do_read(32'(i * 4), rd);
      check("reset_read", rd, 0);
    end

    do_write(32'h08, 32'h0000_00AB, 4'hF);
    check("wr08_kg_data", kg_data, 32'h0000_00AB);
    do_read(32'h08, rd);
    check("wr08_readback", rd, 32'h0000_00AB);

    do_write(32'h00, 32'h1122_3344, 4'hF);
    do_write(32'h00, 32'hFFFF_FFFF, 4'h2);
    @(negedge clk);
    check("strobe_kg_address", kg_address, 32'h1122_FF44);

    // AW without W must stall
    @(posedge clk); #1;
    awaddr = 32'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 0;
    repeat (5) begin
      @(negedge clk);
      check("aw_only_awready", awready, 0);
      check("aw_only_wready", wready, 0);
    end
    @(posedge clk); #1 wvalid = 1;
    @(negedge clk);
    check("aw_w_awready", awready, 1);
    check("aw_w_wready", wready, 1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("aw_w_kg_data_valid", kg_data_valid, 32'h55);

    // B back-pressure blocks a second write
    @(posedge clk); #1 bready = 0;
    awaddr = 32'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    wait_aw_accept("bhold_first");
    @(posedge clk); #1 wdata = 32'h99;
    repeat (4) begin
      @(negedge clk);
      check("bhold_bvalid", bvalid, 1);
      check("bhold_awready", awready, 0);
      check("bhold_kg_data_valid", kg_data_valid, 32'h77);
    end
    @(posedge clk); #1 bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bhold_release_awready", awready, 1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("bhold_second_kg_data_valid", kg_data_valid, 32'h99);

    do_write(32'h24, 32'h5, 4'hF);
    check("alias_kg_address_valid", kg_address_valid, 32'h5);
    do_read(32'h10, rd);
`ifdef AXIL_KG_REGFILE_ID_EN
    check("id_read", rd, 32'h4B47_0001);
`else
    check("id_read", rd, 32'h0);
`endif
    do_write(32'h1C, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h3C, rd);
    check("alias_3c_read", rd, 32'h0);

    // random traffic, including occasional mid-transaction reset
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst     = ($urandom_range(0, 149) == 0);
      awvalid = 1'($urandom_range(0, 1));
      wvalid  = 1'($urandom_range(0, 1));
      awaddr  = $urandom;
      awprot  = 3'($urandom_range(0, 7));
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      arvalid = 1'($urandom_range(0, 1));
      araddr  = $urandom;
      arprot  = 3'($urandom_range(0, 7));
      bready  = ($urandom_range(0, 3) != 0);
      rready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
